// File: rtl/way_age_tracker.sv
// Per-set replacement-age tracker: one saturating age counter and one valid bit
// per way. It applies one event per edge (flush > invalidate > fill > access),
// can halve every age periodically, and reports the lowest invalid way.
module way_age_tracker #(
    parameter int unsigned NUM_WAY                  = 8,
    parameter int unsigned WAY_PTR_WIDTH_IN_BITS    = $clog2(NUM_WAY) + 1,
    parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int unsigned DECAY_PERIOD             = 64
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic                                         access_valid_in,
    input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]             access_way_in,
    input  logic                                         fill_valid_in,
    input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]             fill_way_in,
    input  logic                                         invalidate_valid_in,
    input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]             invalidate_way_in,
    input  logic                                         flush_in,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  age_flatted_out,
    output logic [NUM_WAY-1:0]                           valid_out,
    output logic                                         all_valid_out,
    output logic [WAY_PTR_WIDTH_IN_BITS-1:0]             first_invalid_way_out,
    output logic                                         conflict_out
);

    localparam int unsigned W        = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int unsigned CntW     = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int unsigned CntLast  = (DECAY_PERIOD > 0) ? DECAY_PERIOD - 1 : 0;
    localparam logic [W-1:0] AgeMax  = '1;
    localparam logic [CntW-1:0] CntLastV = CntW'(CntLast);

    logic [NUM_WAY-1:0][W-1:0] age_q, age_d;
    logic [NUM_WAY-1:0]        valid_q, valid_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      conflict_q, conflict_d;

    logic [NUM_WAY-1:0]        acc_oh, fill_oh, inv_oh;
    logic                      acc_hit;
    logic                      decay_tick;
    logic [2:0]                n_evt;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] a);
        return (a == AgeMax) ? a : a + W'(1);
    endfunction

    // Decode way indices to one-hot masks; out-of-range indices match no way.
    always_comb begin
        acc_oh  = '0;
        fill_oh = '0;
        inv_oh  = '0;
        for (int unsigned i = 0; i < NUM_WAY; i++) begin
            acc_oh[i]  = (access_way_in == WAY_PTR_WIDTH_IN_BITS'(i));
            fill_oh[i] = (fill_way_in == WAY_PTR_WIDTH_IN_BITS'(i));
            inv_oh[i]  = (invalidate_way_in == WAY_PTR_WIDTH_IN_BITS'(i));
        end
        acc_hit = |(acc_oh & valid_q);
    end

    // Next-state: apply the single highest-priority event, then the decay shift.
    always_comb begin
        age_d      = age_q;
        valid_d    = valid_q;
        decay_tick = (DECAY_PERIOD != 0) && (cnt_q == CntLastV);
        n_evt      = 3'(flush_in) + 3'(invalidate_valid_in) + 3'(fill_valid_in)
                   + 3'(access_valid_in);
        conflict_d = (n_evt > 3'd1);

        if (flush_in) begin
            age_d   = '0;
            valid_d = '0;
        end else if (invalidate_valid_in) begin
            for (int unsigned i = 0; i < NUM_WAY; i++) begin
                if (inv_oh[i]) begin
                    valid_d[i] = 1'b0;
                    age_d[i]   = '0;
                end
            end
        end else if (fill_valid_in) begin
            if (|fill_oh) begin
                for (int unsigned i = 0; i < NUM_WAY; i++) begin
                    if (fill_oh[i]) begin
                        valid_d[i] = 1'b1;
                        age_d[i]   = '0;
                    end else if (valid_q[i]) begin
                        age_d[i] = sat_inc(age_q[i]);
                    end
                end
            end
        end else if (access_valid_in && acc_hit) begin
            for (int unsigned i = 0; i < NUM_WAY; i++) begin
                if (acc_oh[i]) begin
                    age_d[i] = '0;
                end else if (valid_q[i]) begin
                    age_d[i] = sat_inc(age_q[i]);
                end
            end
        end

        if (decay_tick) begin
            for (int unsigned i = 0; i < NUM_WAY; i++) begin
                age_d[i] = age_d[i] >> 1;
            end
        end

        if (flush_in || (DECAY_PERIOD == 0) || decay_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // State registers with synchronous reset overriding all events.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            age_q      <= '0;
            valid_q    <= '0;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            age_q      <= age_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    // Lowest invalid way; scanning downward lets the lowest index win.
    always_comb begin
        first_invalid_way_out = '0;
        for (int i = int'(NUM_WAY) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                first_invalid_way_out = WAY_PTR_WIDTH_IN_BITS'(i);
            end
        end
    end

    assign age_flatted_out = age_q;
    assign valid_out       = valid_q;
    assign all_valid_out   = &valid_q;
    assign conflict_out    = conflict_q;

endmodule

// File: tb/tb_way_age_tracker.sv
// Directed bench for way_age_tracker: a no-decay instance covers event
// handling and saturation, a DECAY_PERIOD=4 instance covers the halving.
module tb_way_age_tracker;

    localparam int NW = 8;
    localparam int PW = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, acc_v, fill_v, inv_v, flush;
    logic [PW-1:0] acc_w, fill_w, inv_w;

    logic [AW*NW-1:0] age_m, age_y;
    logic [NW-1:0]    val_m, val_y;
    logic             allv_m, allv_y;
    logic [PW-1:0]    fi_m, fi_y;
    logic             cf_m, cf_y;

    int n_vec  = 0;
    int n_miss = 0;

    way_age_tracker #(
        .NUM_WAY                  (NW),
        .WAY_PTR_WIDTH_IN_BITS    (PW),
        .SINGLE_WAY_WIDTH_IN_BITS (AW),
        .DECAY_PERIOD             (0)
    ) u_dut (
        .clk_in                (clk),
        .reset_in              (rst),
        .access_valid_in       (acc_v),
        .access_way_in         (acc_w),
        .fill_valid_in         (fill_v),
        .fill_way_in           (fill_w),
        .invalidate_valid_in   (inv_v),
        .invalidate_way_in     (inv_w),
        .flush_in              (flush),
        .age_flatted_out       (age_m),
        .valid_out             (val_m),
        .all_valid_out         (allv_m),
        .first_invalid_way_out (fi_m),
        .conflict_out          (cf_m)
    );

    way_age_tracker #(
        .NUM_WAY                  (NW),
        .WAY_PTR_WIDTH_IN_BITS    (PW),
        .SINGLE_WAY_WIDTH_IN_BITS (AW),
        .DECAY_PERIOD             (4)
    ) u_dcy (
        .clk_in                (clk),
        .reset_in              (rst),
        .access_valid_in       (acc_v),
        .access_way_in         (acc_w),
        .fill_valid_in         (fill_v),
        .fill_way_in           (fill_w),
        .invalidate_valid_in   (inv_v),
        .invalidate_way_in     (inv_w),
        .flush_in              (flush),
        .age_flatted_out       (age_y),
        .valid_out             (val_y),
        .all_valid_out         (allv_y),
        .first_invalid_way_out (fi_y),
        .conflict_out          (cf_y)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given events; inputs return to idle 1ns after the edge.
    task automatic cyc(input logic r, input logic fl, input logic iv, input logic [PW-1:0] iw,
                       input logic fv, input logic [PW-1:0] fw,
                       input logic av, input logic [PW-1:0] aw);
        rst = r; flush = fl;
        inv_v = iv; inv_w = iw;
        fill_v = fv; fill_w = fw;
        acc_v = av; acc_w = aw;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; inv_v = 1'b0; fill_v = 1'b0; acc_v = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic fill(input logic [PW-1:0] w);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, w, 1'b0, 4'd0);
    endtask

    task automatic acc(input logic [PW-1:0] w);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, w);
    endtask

    task automatic inv(input logic [PW-1:0] w);
        cyc(1'b0, 1'b0, 1'b1, w, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    // Full check of the no-decay instance.
    task automatic chk_m(input string tag, input logic [31:0] age, input logic [7:0] val,
                         input logic [3:0] fi, input logic cf);
        check_eq({tag, ".age"}, 64'(age_m), 64'(age));
        check_eq({tag, ".valid"}, 64'(val_m), 64'(val));
        check_eq({tag, ".all_valid"}, 64'(allv_m), 64'(&val));
        check_eq({tag, ".first_inv"}, 64'(fi_m), 64'(fi));
        check_eq({tag, ".conflict"}, 64'(cf_m), 64'(cf));
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; inv_v = 1'b0; fill_v = 1'b0; acc_v = 1'b0;
        acc_w = '0; fill_w = '0; inv_w = '0;

        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        chk_m("reset", 32'h0, 8'h00, 4'd0, 1'b0);

        fill(4'd0); fill(4'd1); fill(4'd2);
        chk_m("fill012", 32'h0000_0012, 8'h07, 4'd3, 1'b0);

        acc(4'd0);
        chk_m("acc0", 32'h0000_0120, 8'h07, 4'd3, 1'b0);
        acc(4'd5);
        chk_m("acc_invalid5", 32'h0000_0120, 8'h07, 4'd3, 1'b0);

        for (int w = 3; w < 8; w++) fill(4'(w));
        chk_m("fill_all", 32'h0123_4675, 8'hFF, 4'd0, 1'b0);

        for (int k = 0; k < 20; k++) acc(4'd7);
        chk_m("saturate", 32'h0FFF_FFFF, 8'hFF, 4'd0, 1'b0);

        // invalidate 2, fill 3, access 1 together: only the invalidate lands
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1);
        chk_m("triple_evt", 32'h0FFF_F0FF, 8'hFB, 4'd2, 1'b1);
        idle();
        chk_m("conflict_pulse", 32'h0FFF_F0FF, 8'hFB, 4'd2, 1'b0);

        fill(4'd0);
        chk_m("fill_reinstall", 32'h1FFF_F0F0, 8'hFB, 4'd2, 1'b0);

        inv(4'd8);
        chk_m("inv_oob", 32'h1FFF_F0F0, 8'hFB, 4'd2, 1'b0);
        acc(4'd2);
        chk_m("acc_invalid2", 32'h1FFF_F0F0, 8'hFB, 4'd2, 1'b0);

        fill(4'd2);
        chk_m("refill2", 32'h2FFF_F0F1, 8'hFF, 4'd0, 1'b0);

        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1);
        chk_m("flush_acc", 32'h0, 8'h00, 4'd0, 1'b1);

        fill(4'd0);
        chk_m("post_flush_fill", 32'h0, 8'h01, 4'd1, 1'b0);

        cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0);
        chk_m("reset_fill", 32'h0, 8'h00, 4'd0, 1'b0);

        // Decay instance: flush aligns its counter, then edge 4k halves ages.
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        fill(4'd0); fill(4'd1); acc(4'd1);
        check_eq("dcy_pre", 64'(age_y), 64'h2);
        check_eq("dcy_valid", 64'(val_y), 64'h3);
        acc(4'd1);
        check_eq("dcy_acc_on_decay1", 64'(age_y), 64'h1);
        acc(4'd0); acc(4'd0); acc(4'd0);
        check_eq("dcy_grow", 64'(age_y), 64'h30);
        acc(4'd0);
        check_eq("dcy_acc_on_decay2", 64'(age_y), 64'h20);
        acc(4'd1); acc(4'd1); acc(4'd1);
        check_eq("dcy_grow2", 64'(age_y), 64'h03);
        idle();
        check_eq("dcy_idle_shift", 64'(age_y), 64'h01);
        idle(); idle(); idle();
        check_eq("dcy_hold", 64'(age_y), 64'h01);
        idle();
        check_eq("dcy_wrap", 64'(age_y), 64'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/way_age_tracker.md
Name: way_age_tracker

Overview:
- Per-set replacement-age state for one cache set.
- Holds a saturating age counter and a valid bit for each way, and updates them on access, fill, invalidate and flush events.
- Publishes the flattened age vector and valid mask. The downstream max-select tree consumes these directly as its value and condition inputs to find the oldest valid way.
- Also reports the lowest invalid way, so the fill path can prefer an empty way over eviction.

Parameters:
- NUM_WAY, 8: number of ways. Legal values are 1, 2, 4, 8, 16.
- WAY_PTR_WIDTH_IN_BITS, $clog2(NUM_WAY)+1: width of way index ports.
- SINGLE_WAY_WIDTH_IN_BITS, 4: width of each age counter. Saturates at 2^W-1.
- DECAY_PERIOD, 64: cycles between global age halvings. 0 disables decay.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- access_valid_in  input  1  hit/touch event.
- access_way_in  input  WAY_PTR_WIDTH_IN_BITS  way touched.
- fill_valid_in  input  1  line installed.
- fill_way_in  input  WAY_PTR_WIDTH_IN_BITS  way filled.
- invalidate_valid_in  input  1  line removed.
- invalidate_way_in  input  WAY_PTR_WIDTH_IN_BITS  way invalidated.
- flush_in  input  1  clear the whole set.
- age_flatted_out  output  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  registered ages; way i is at [i*W +: W].
- valid_out  output  NUM_WAY  registered valid mask; bit i is way i.
- all_valid_out  output  1  AND of valid_out.
- first_invalid_way_out  output  WAY_PTR_WIDTH_IN_BITS  lowest index with valid=0. Equals 0 when all_valid_out=1.
- conflict_out  output  1  registered one-cycle pulse: a lower-priority event was dropped this cycle.

Behaviour:
- Reset (reset_in=1 at an edge):
  - all ages 0, valid_out 0, conflict_out 0, decay counter 0.
  - all_valid_out is 0 and first_invalid_way_out is 0.
  - Reset overrides every event in the same cycle.
- Exactly one event is applied per cycle. Priority: flush > invalidate > fill > access.
  - conflict_out is 1 the next cycle if two or more event valids were asserted.
  - Dropped events have no effect.
- Flush: all ages 0, all valid 0, decay counter 0.
- Invalidate way w: valid[w]=0 and age[w]=0. Other ways are unchanged.
- Fill way w:
  - valid[w]=1, age[w]=0.
  - Every other way that is valid before the edge increments its age, saturating at 2^W-1.
  - Filling an already-valid way behaves identically, i.e. it is treated as a re-install.
- Access way w:
  - If valid[w]=1: age[w]=0 and every other valid way saturating-increments.
  - If valid[w]=0: no state change and no conflict.
- Invalid ways always hold age 0. A way index >= NUM_WAY is ignored (no state change).
- Decay, when DECAY_PERIOD>0:
  - The free-running cycle counter counts 0..DECAY_PERIOD-1 and wraps.
  - On the cycle the counter equals DECAY_PERIOD-1, every age is logically shifted right by 1 after that cycle's event update is applied.
  - Example: an access producing age 5 that cycle yields 2.
  - Flush and reset zero the counter.
- Latency:
  - age_flatted_out and valid_out reflect an event one cycle after the event's edge, i.e. registered outputs.
  - all_valid_out and first_invalid_way_out are combinational from the valid register, so they carry no extra latency beyond the register.
- Saturating increment never wraps: 15 stays 15 when W=4.
- Outputs feed the max-select stage unmodified. Ties there resolve to the higher index, so this block imposes no ordering.

Test Plan:
1. Reset then fill ways 0,1,2 on consecutive cycles.
   - After the third edge: valid_out=8'b0000_0111, ages {w0=2, w1=1, w2=0}.
   - first_invalid_way_out=3.
2. From state 1, access way 0.
   - Ages become {w0=0, w1=2, w2=1}; invalid ways stay 0.
   - Then access way 5 (invalid): no change.
3. Fill all 8 ways, then access way 7 twenty times.
   - Ways 0..6 saturate at 15, way 7 stays 0.
   - all_valid_out=1 and first_invalid_way_out=0.
4. Same cycle: fill way 3, access way 1, invalidate way 2.
   - Only the invalidate takes effect: valid[2]=0, age[2]=0.
   - conflict_out=1 for exactly one cycle.
5. DECAY_PERIOD=4 with ages {w0=9, w1=6}, no events.
   - At the 4th edge after reset/flush the ages become {4, 3}.
   - An access to w1 on the decay cycle gives {w0=(9+1)>>1=5, w1=0}.
6. Assert flush_in mid-stream while access_valid_in=1.
   - Next cycle: all ages 0, valid_out=0, conflict_out=1.
   - Assert reset_in together with fill: state is all-zero and conflict_out=0.
